// File: rtl/hall_emulator.sv
// hall_emulator: rotor physics and Hall-sensor model closing the loop around a BLDC commutator.
// Define HALL_EMU_ERRCNT_EN to build the saturating misalignment counter behind err_cnt.
module hall_emulator #(
    parameter int PRESC_W     = 4,
    parameter int VEL_W       = 12,
    parameter int STEP_THRESH = 4096,
    parameter int FRIC_SHIFT  = 6,
    parameter int REGEN_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       selGrn,
    input  logic [1:0]       selYlw,
    input  logic [1:0]       selBlu,
    input  logic [10:0]      duty,
    output logic             hallGrn,
    output logic             hallYlw,
    output logic             hallBlu,
    output logic [2:0]       sector,
    output logic [VEL_W-1:0] velocity,
    output logic             comm_err,
    output logic [7:0]       err_cnt
);
    localparam int POS_W = $clog2(STEP_THRESH) + 1;
    localparam int SW    = VEL_W + 2;

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} sector_e;

    sector_e            sector_q, sector_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [VEL_W-1:0]   vel_q, vel_d, vel_clamp;
    logic [POS_W-1:0]   pos_q, pos_d, pos_sum;
    logic [2:0]         hall_q, hall_d;
    logic               comm_err_q, comm_err_d;
    logic [5:0]         drive, exp_drive;
    logic [SW-1:0]      torque, v_next;
    logic               tick, regen, coast, aligned, misaligned, step;

    always_comb begin
        tick    = presc_q == {PRESC_W{1'b1}};
        presc_d = presc_q + 1'b1;
        drive   = {selGrn, selYlw, selBlu};
        case (sector_q)
            S1:      begin exp_drive = 6'b100001; hall_d = 3'b100; end
            S2:      begin exp_drive = 6'b001001; hall_d = 3'b110; end
            S3:      begin exp_drive = 6'b011000; hall_d = 3'b010; end
            S4:      begin exp_drive = 6'b010010; hall_d = 3'b011; end
            S5:      begin exp_drive = 6'b000110; hall_d = 3'b001; end
            default: begin exp_drive = 6'b100100; hall_d = 3'b101; end
        endcase
        // regen and coast take priority over the alignment test
        regen      = &drive;
        coast      = ~|drive;
        aligned    = !regen && !coast && drive == exp_drive;
        misaligned = !regen && !coast && !aligned;
        torque     = (aligned && duty[10]) ? SW'(duty[9:0]) : '0;
        v_next     = SW'(vel_q) + torque - SW'(vel_q >> FRIC_SHIFT)
                   - (regen ? SW'(vel_q >> REGEN_SHIFT) : '0);
        vel_clamp  = v_next[SW-1] ? '0 : (|v_next[SW-2:VEL_W]) ? '1 : v_next[VEL_W-1:0];
        // position advances with the pre-update velocity
        pos_sum    = pos_q + POS_W'(vel_q);
        step       = pos_sum >= POS_W'(STEP_THRESH);
        vel_d      = tick ? vel_clamp : vel_q;
        pos_d      = !tick ? pos_q : step ? pos_sum - POS_W'(STEP_THRESH) : pos_sum;
        sector_d   = !(tick && step) ? sector_q : (sector_q == S5) ? S0 : sector_e'(sector_q + 3'd1);
        comm_err_d = tick && misaligned;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            vel_q      <= '0;
            pos_q      <= '0;
            sector_q   <= S0;
            hall_q     <= 3'b101;
            comm_err_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            vel_q      <= vel_d;
            pos_q      <= pos_d;
            sector_q   <= sector_d;
            hall_q     <= hall_d;
            comm_err_q <= comm_err_d;
        end
    end

`ifdef HALL_EMU_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = (comm_err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign {hallGrn, hallYlw, hallBlu} = hall_q;
    assign sector   = sector_q;
    assign velocity = vel_q;
    assign comm_err = comm_err_q;
endmodule
